// File: rtl/cache_fill_ctrl.sv
// Miss/fill and full-invalidate sequencer for a set-associative cache.
// Optional: define CACHE_FILL_LFSR_VICTIM_EN to pick full-set victims from an 8-bit LFSR instead of round-robin.
module cache_fill_ctrl #(
  parameter int LINES  = 256,
  parameter int WAYS   = 4,
  parameter int AWID   = 32,
  parameter int DW     = 128,
  parameter int BEATS  = 4,
  parameter int TAGBIT = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      miss_req,
  input  logic [AWID-1:0]           miss_adr,
  input  logic [WAYS-1:0]           way_valid,
  output logic                      miss_ack,
  output logic                      fill_err,
  input  logic                      inv_all,
  output logic                      inv_ack,
  output logic                      busy,
  output logic                      mem_req,
  output logic [AWID-1:0]           mem_adr,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [DW-1:0]             mem_rdata,
  input  logic                      mem_rerr,
  output logic                      wr_en,
  output logic [$clog2(WAYS)-1:0]   wr_way,
  output logic [$clog2(LINES)-1:0]  wr_ndx,
  output logic [$clog2(BEATS)-1:0]  wr_beat,
  output logic [DW-1:0]             wr_data,
  output logic                      tag_we,
  output logic [AWID-TAGBIT-1:0]    tag_out,
  output logic                      valid_set,
  output logic [WAYS-1:0]           valid_clr
);

  localparam int WAYW  = $clog2(WAYS);
  localparam int NDXW  = $clog2(LINES);
  localparam int BEATW = $clog2(BEATS);
  localparam int TAGW  = AWID - TAGBIT;
  localparam int OFFW  = TAGBIT - NDXW;
  localparam logic [AWID-1:0] OFF_MASK = {{(AWID-OFFW){1'b0}}, {OFFW{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_FILL = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4,
    S_INV  = 3'd5
  } state_t;

  function automatic logic [WAYS-1:0] f_onehot(input logic [WAYW-1:0] way);
    f_onehot      = '0;
    f_onehot[way] = 1'b1;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BEATW-1:0]  r_beat_cnt;
  logic [BEATW-1:0]  w_beat_cnt_nxt;
  logic [AWID-1:0]   w_adr_line;
  logic              w_free_found;
  logic [WAYW-1:0]   w_free_way;
  logic [WAYW-1:0]   w_repl_way;
  logic [WAYW-1:0]   w_victim;
  logic              w_victim_sel;

  logic              w_miss_ack_nxt;
  logic              w_fill_err_nxt;
  logic              w_inv_ack_nxt;
  logic              w_mem_req_nxt;
  logic [AWID-1:0]   w_mem_adr_nxt;
  logic              w_wr_en_nxt;
  logic [WAYW-1:0]   w_wr_way_nxt;
  logic [NDXW-1:0]   w_wr_ndx_nxt;
  logic [BEATW-1:0]  w_wr_beat_nxt;
  logic [DW-1:0]     w_wr_data_nxt;
  logic              w_tag_we_nxt;
  logic [TAGW-1:0]   w_tag_out_nxt;
  logic              w_valid_set_nxt;
  logic [WAYS-1:0]   w_valid_clr_nxt;

  assign w_adr_line   = miss_adr & ~OFF_MASK;
  assign w_free_found = ~&way_valid;
  assign w_victim     = w_free_found ? w_free_way : w_repl_way;

  // Lowest-numbered invalid way at the miss set.
  always_comb begin
    w_free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      w_free_way = way_valid[i] ? w_free_way : WAYW'(i);
    end
  end

`ifdef CACHE_FILL_LFSR_VICTIM_EN
  logic [7:0] r_lfsr;

  assign w_repl_way = r_lfsr[WAYW-1:0];

  // Galois LFSR x^8+x^6+x^5+x^4+1, stepped once per accepted miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 8'h01;
    end else if (w_victim_sel) begin
      r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ 8'hB8) : (r_lfsr >> 1);
    end else begin
      r_lfsr <= r_lfsr;
    end
  end
`else
  logic [WAYW-1:0] r_rr;

  assign w_repl_way = r_rr;

  // Round-robin pointer advances only when a fully valid set forces replacement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_victim_sel && !w_free_found) begin
      r_rr <= r_rr + WAYW'(1);
    end else begin
      r_rr <= r_rr;
    end
  end
`endif

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_victim_sel    = 1'b0;
    w_miss_ack_nxt  = 1'b0;
    w_fill_err_nxt  = 1'b0;
    w_inv_ack_nxt   = 1'b0;
    w_mem_req_nxt   = 1'b0;
    w_mem_adr_nxt   = mem_adr;
    w_wr_en_nxt     = 1'b0;
    w_wr_way_nxt    = wr_way;
    w_wr_ndx_nxt    = wr_ndx;
    w_wr_beat_nxt   = wr_beat;
    w_wr_data_nxt   = wr_data;
    w_tag_we_nxt    = 1'b0;
    w_tag_out_nxt   = tag_out;
    w_valid_set_nxt = 1'b0;
    w_valid_clr_nxt = '0;
    case (r_state)
      S_IDLE: begin
        // The ack cycle is skipped so a still-held request is not taken twice.
        if (miss_ack || inv_ack) begin
          w_state_nxt = S_IDLE;
        end else if (inv_all) begin
          w_state_nxt     = S_INV;
          w_wr_ndx_nxt    = '0;
          w_valid_clr_nxt = {WAYS{1'b1}};
        end else if (miss_req) begin
          w_state_nxt     = S_REQ;
          w_victim_sel    = 1'b1;
          w_beat_cnt_nxt  = '0;
          w_mem_req_nxt   = 1'b1;
          w_mem_adr_nxt   = w_adr_line;
          w_wr_way_nxt    = w_victim;
          w_wr_ndx_nxt    = w_adr_line[TAGBIT-1:OFFW];
          w_tag_out_nxt   = w_adr_line[AWID-1:TAGBIT];
          w_valid_clr_nxt = f_onehot(w_victim);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          w_state_nxt   = S_FILL;
          w_mem_req_nxt = 1'b0;
        end else begin
          w_state_nxt   = S_REQ;
          w_mem_req_nxt = 1'b1;
        end
      end
      S_FILL: begin
        if (mem_rvalid && mem_rerr) begin
          w_state_nxt    = S_ERR;
          w_beat_cnt_nxt = '0;
        end else if (mem_rvalid) begin
          w_wr_en_nxt    = 1'b1;
          w_wr_beat_nxt  = r_beat_cnt;
          w_wr_data_nxt  = mem_rdata;
          w_beat_cnt_nxt = r_beat_cnt + BEATW'(1);
          if (r_beat_cnt == BEATW'(BEATS - 1)) begin
            w_state_nxt     = S_DONE;
            w_tag_we_nxt    = 1'b1;
            w_valid_set_nxt = 1'b1;
          end else begin
            w_state_nxt = S_FILL;
          end
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      S_DONE: begin
        w_state_nxt    = S_IDLE;
        w_miss_ack_nxt = 1'b1;
      end
      S_ERR: begin
        w_state_nxt    = S_IDLE;
        w_miss_ack_nxt = 1'b1;
        w_fill_err_nxt = 1'b1;
      end
      S_INV: begin
        if (wr_ndx == NDXW'(LINES - 1)) begin
          w_state_nxt   = S_IDLE;
          w_inv_ack_nxt = 1'b1;
        end else begin
          w_state_nxt     = S_INV;
          w_wr_ndx_nxt    = wr_ndx + NDXW'(1);
          w_valid_clr_nxt = {WAYS{1'b1}};
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, beat counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      miss_ack   <= 1'b0;
      fill_err   <= 1'b0;
      inv_ack    <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_adr    <= '0;
      wr_en      <= 1'b0;
      wr_way     <= '0;
      wr_ndx     <= '0;
      wr_beat    <= '0;
      wr_data    <= '0;
      tag_we     <= 1'b0;
      tag_out    <= '0;
      valid_set  <= 1'b0;
      valid_clr  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      miss_ack   <= w_miss_ack_nxt;
      fill_err   <= w_fill_err_nxt;
      inv_ack    <= w_inv_ack_nxt;
      busy       <= (w_state_nxt != S_IDLE);
      mem_req    <= w_mem_req_nxt;
      mem_adr    <= w_mem_adr_nxt;
      wr_en      <= w_wr_en_nxt;
      wr_way     <= w_wr_way_nxt;
      wr_ndx     <= w_wr_ndx_nxt;
      wr_beat    <= w_wr_beat_nxt;
      wr_data    <= w_wr_data_nxt;
      tag_we     <= w_tag_we_nxt;
      tag_out    <= w_tag_out_nxt;
      valid_set  <= w_valid_set_nxt;
      valid_clr  <= w_valid_clr_nxt;
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: vector table, invalidate and reset sequences,
// then randomized misses against a transaction-level reference model.
module tb_cache_fill_ctrl;

  logic         clk;
  logic         rst_n;
  logic         miss_req;
  logic [31:0]  miss_adr;
  logic [3:0]   way_valid;
  logic         miss_ack;
  logic         fill_err;
  logic         inv_all;
  logic         inv_ack;
  logic         busy;
  logic         mem_req;
  logic [31:0]  mem_adr;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic         mem_rerr;
  logic         wr_en;
  logic [1:0]   wr_way;
  logic [7:0]   wr_ndx;
  logic [1:0]   wr_beat;
  logic [127:0] wr_data;
  logic         tag_we;
  logic [17:0]  tag_out;
  logic         valid_set;
  logic [3:0]   valid_clr;

  int n_cmp = 0;
  int n_err = 0;
  int m_rr  = 0;

  cache_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_adr(miss_adr),
    .way_valid(way_valid), .miss_ack(miss_ack), .fill_err(fill_err),
    .inv_all(inv_all), .inv_ack(inv_ack), .busy(busy), .mem_req(mem_req),
    .mem_adr(mem_adr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rerr(mem_rerr), .wr_en(wr_en), .wr_way(wr_way),
    .wr_ndx(wr_ndx), .wr_beat(wr_beat), .wr_data(wr_data), .tag_we(tag_we),
    .tag_out(tag_out), .valid_set(valid_set), .valid_clr(valid_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  wv;
    int          gd;
    int          gap;
    int          errb;
    logic [1:0]  ev;
    logic [31:0] em;
    logic [7:0]  en;
    logic [17:0] et;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {miss_ack, fill_err, inv_ack, busy, mem_req, mem_adr, wr_en, wr_way, wr_ndx,
             wr_beat, wr_data, tag_we, tag_out, valid_set, valid_clr}, '0);
  endtask

  // Reference victim choice: first invalid way, else rotating pointer.
  function automatic logic [1:0] model_victim(input logic [3:0] wv);
    logic [1:0] v;
    for (int i = 0; i < 4; i++) begin
      if (wv[i] == 1'b0) return 2'(i);
    end
    v    = 2'(m_rr);
    m_rr = (m_rr + 1) % 4;
    return v;
  endfunction

  // One complete miss transaction; gap < 0 means a random gap before every beat, errb 4 means no error.
  task automatic do_miss(input logic [31:0] adr, input logic [3:0] wv, input int gd, input int gap,
                         input int errb, input logic [1:0] ev, input logic [31:0] em,
                         input logic [7:0] en, input logic [17:0] et);
    logic [127:0] d;
    logic [3:0]   oh;
    int           ng;
    oh        = 4'b0001 << ev;
    miss_req  = 1'b1;
    miss_adr  = adr;
    way_valid = wv;
    @(negedge clk);
    chk("req_start", mem_req, 1'b1);
    chk("mem_adr", mem_adr, em);
    chk("valid_clr", valid_clr, oh);
    chk("wr_way", wr_way, ev);
    chk("wr_ndx", wr_ndx, en);
    chk("busy", busy, 1'b1);
    miss_adr  = $urandom;
    way_valid = 4'($urandom_range(0, 15));
    for (int k = 0; k < gd; k++) begin
      @(negedge clk);
      chk("mem_req_hold", mem_req, 1'b1);
      chk("mem_adr_hold", mem_adr, em);
      chk("valid_clr_pulse", valid_clr, 4'b0000);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("mem_req_drop", mem_req, 1'b0);
    for (int b = 0; b < 4; b++) begin
      ng = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int g = 0; g < ng; g++) begin
        @(negedge clk);
        chk("gap_no_wr", wr_en, 1'b0);
      end
      d          = {$urandom, $urandom, $urandom, $urandom};
      mem_rvalid = 1'b1;
      mem_rdata  = d;
      mem_rerr   = (b == errb);
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rerr   = 1'b0;
      mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
      chk("miss_ack_early", miss_ack, 1'b0);
      if (b == errb) begin
        chk("err_no_wr", wr_en, 1'b0);
        chk("err_no_tag", tag_we, 1'b0);
        break;
      end
      chk("wr_en", wr_en, 1'b1);
      chk("wr_beat", wr_beat, b);
      chk("wr_data", wr_data, d);
      chk("wr_way_fill", wr_way, ev);
      chk("wr_ndx_fill", wr_ndx, en);
      chk("tag_we", tag_we, b == 3);
      chk("valid_set", valid_set, b == 3);
      if (b == 3) chk("tag_out", tag_out, et);
    end
    @(negedge clk);
    chk("miss_ack", miss_ack, 1'b1);
    chk("fill_err", fill_err, errb < 4);
    chk("ack_no_valid_set", valid_set, 1'b0);
    chk("ack_busy", busy, 1'b0);
    @(negedge clk);
    chk("ack_pulse", miss_ack, 1'b0);
    chk("no_resample", busy, 1'b0);
    miss_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr;
    logic [3:0]  wv;
    logic [1:0]  ev;
    int          gd;
    int          errb;

    tv[0]  = '{32'h0001_2340, 4'b0000, 0, 0, 4, 2'd0, 32'h0001_2340, 8'h8D, 18'h00004};
    tv[1]  = '{32'h0001_2340, 4'b1111, 0, 0, 4, 2'd0, 32'h0001_2340, 8'h8D, 18'h00004};
    tv[2]  = '{32'h0005_2355, 4'b1111, 1, 1, 4, 2'd1, 32'h0005_2340, 8'h8D, 18'h00014};
    tv[3]  = '{32'hFFFF_E37F, 4'b1111, 0, 0, 4, 2'd2, 32'hFFFF_E340, 8'h8D, 18'h3FFFF};
    tv[4]  = '{32'h0000_2340, 4'b1111, 2, 0, 4, 2'd3, 32'h0000_2340, 8'h8D, 18'h00000};
    tv[5]  = '{32'h0001_2340, 4'b1111, 0, 0, 4, 2'd0, 32'h0001_2340, 8'h8D, 18'h00004};
    tv[6]  = '{32'h1234_5678, 4'b0101, 0, 2, 4, 2'd1, 32'h1234_5640, 8'h59, 18'h048D1};
    tv[7]  = '{32'h0000_0000, 4'b1011, 1, 0, 4, 2'd2, 32'h0000_0000, 8'h00, 18'h00000};
    tv[8]  = '{32'hFFFF_FFFF, 4'b0111, 0, 0, 4, 2'd3, 32'hFFFF_FFC0, 8'hFF, 18'h3FFFF};
    tv[9]  = '{32'h0001_2340, 4'b1111, 0, 0, 2, 2'd1, 32'h0001_2340, 8'h8D, 18'h00004};
    tv[10] = '{32'h0001_2340, 4'b1111, 5, 3, 4, 2'd2, 32'h0001_2340, 8'h8D, 18'h00004};
    tv[11] = '{32'h0000_0040, 4'b1110, 0, 0, 0, 2'd0, 32'h0000_0040, 8'h01, 18'h00000};
    tv[12] = '{32'h0000_0040, 4'b0000, 0, 1, 3, 2'd0, 32'h0000_0040, 8'h01, 18'h00000};

    rst_n      = 1'b0;
    miss_req   = 1'b0;
    miss_adr   = 32'h0000_0000;
    way_valid  = 4'b0000;
    inv_all    = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 128'h0;
    mem_rerr   = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle_after_reset");

    for (int i = 0; i < 13; i++) begin
      void'(model_victim(tv[i].wv));
      do_miss(tv[i].adr, tv[i].wv, tv[i].gd, tv[i].gap, tv[i].errb,
              tv[i].ev, tv[i].em, tv[i].en, tv[i].et);
    end

    // Invalidate and miss raised together: the full sweep runs first, then the fill.
    miss_req  = 1'b1;
    miss_adr  = 32'h0001_2340;
    way_valid = 4'b0000;
    inv_all   = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    for (int i = 0; i < 256; i++) begin
      chk("inv_valid_clr", valid_clr, 4'b1111);
      chk("inv_ndx", wr_ndx, i);
      chk("inv_busy", busy, 1'b1);
      chk("inv_no_mem_req", mem_req, 1'b0);
      @(negedge clk);
    end
    chk("inv_ack", inv_ack, 1'b1);
    chk("inv_ack_clr_done", valid_clr, 4'b0000);
    chk("inv_ack_idle", busy, 1'b0);
    @(negedge clk);
    chk("inv_ack_pulse", inv_ack, 1'b0);
    chk("inv_then_idle", mem_req, 1'b0);
    void'(model_victim(4'b0000));
    do_miss(32'h0001_2340, 4'b0000, 0, 0, 4, 2'd0, 32'h0001_2340, 8'h8D, 18'h00004);

    // Reset asserted while beat 1 is being written.
    miss_req  = 1'b1;
    miss_adr  = 32'h0001_2340;
    way_valid = 4'b0000;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #2;
    chk("beat1_wr_en", wr_en, 1'b1);
    chk("beat1_wr_beat", wr_beat, 2'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset_outputs");
    miss_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stray_beat_no_wr", wr_en, 1'b0);
      chk("stray_beat_no_valid", valid_set, 1'b0);
      chk("stray_beat_idle", busy, 1'b0);
    end
    mem_rvalid = 1'b0;
    m_rr = 0;

    for (int r = 0; r < 40; r++) begin
      adr  = $urandom;
      wv   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      gd   = $urandom_range(0, 3);
      errb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 4;
      ev   = model_victim(wv);
      do_miss(adr, wv, gd, -1, errb, ev, adr & ~32'h0000_003F,
              8'((adr >> 6) % 256), 18'(adr >> 14));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
